// File: rtl/dmem_pkg.sv
// Shared types and lane helpers for the byte-lane data memory.
// Covers MIPS sb/sh/sw and lb/lbu/lh/lhu/lw access shapes.
package dmem_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } access_size_e;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_IDLE = 1'b1
  } dmem_state_e;

  function automatic logic [3:0] byte_enable(
    input access_size_e size,
    input logic [1:0]   lo
  );
    logic [3:0] be;
    be = 4'b0000;
    unique case (size)
      SZ_BYTE: be = 4'b0001 << lo;
      SZ_HALF: be = lo[1] ? 4'b1100 : 4'b0011;
      SZ_WORD: be = 4'b1111;
      default: be = 4'b0000;
    endcase
    return be;
  endfunction

  function automatic logic is_misaligned(
    input access_size_e size,
    input logic [1:0]   lo
  );
    logic m;
    m = 1'b0;
    unique case (size)
      SZ_BYTE: m = 1'b0;
      SZ_HALF: m = lo[0];
      SZ_WORD: m = |lo;
      default: m = 1'b1;
    endcase
    return m;
  endfunction

  function automatic logic [31:0] extend_load(
    input logic [31:0]  w,
    input access_size_e size,
    input logic [1:0]   lo,
    input logic         uns
  );
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = 8'(w >> {lo, 3'b000});
    h = lo[1] ? w[31:16] : w[15:0];
    r = '0;
    unique case (size)
      SZ_BYTE: r = uns ? {24'd0, b} : {{24{b[7]}}, b};
      SZ_HALF: r = uns ? {16'd0, h} : {{16{h[15]}}, h};
      SZ_WORD: r = w;
      default: r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/data_memory_bytelane_resp.sv
// Response shift register carrying {valid, fault, data} to the writeback mux.
// Only the valid bits are reset; payload is gated by valid at the output.
module dmem_resp_pipe #(
  parameter int LAT = 1,
  parameter int W   = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic         in_fault,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  output logic         out_fault,
  output logic [W-1:0] out_data
);

  logic [LAT-1:0] v_q;
  logic [LAT-1:0] f_q;
  logic [W-1:0]   d_q [LAT];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_q <= '0;
    end else begin
      v_q[0] <= in_valid;
      for (int i = 1; i < LAT; i++) begin
        v_q[i] <= v_q[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    f_q[0] <= in_fault;
    d_q[0] <= in_data;
    for (int i = 1; i < LAT; i++) begin
      f_q[i] <= f_q[i-1];
      d_q[i] <= d_q[i-1];
    end
  end

  assign out_valid = v_q[LAT-1];
  assign out_fault = v_q[LAT-1] & f_q[LAT-1];
  assign out_data  = v_q[LAT-1] ? d_q[LAT-1] : '0;

endmodule

// File: rtl/data_memory_bytelane.sv
// Byte-lane data memory between the ALU/rt stage and writeback.
// Optional clear sweep after reset, misalignment faults, pipelined loads.
module data_memory_bytelane
  import dmem_pkg::*;
#(
  parameter int ADDR_WIDTH     = 12,
  parameter int DATA_WIDTH     = 32,
  parameter int READ_LATENCY   = 1,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [ADDR_WIDTH-1:0] Address,
  input  logic [DATA_WIDTH-1:0] Write_data,
  output logic                  resp_valid,
  output logic [DATA_WIDTH-1:0] Read_data,
  output logic                  misaligned_fault,
  output logic                  init_done
);

  localparam int IW    = ADDR_WIDTH - 2;
  localparam int DEPTH = 2 ** IW;
  localparam dmem_state_e RST_ST =
    (CLEAR_ON_RESET != 0) ? ST_INIT : ST_IDLE;

  if (DATA_WIDTH != 32) begin : g_bad_dw
    $error("data_memory_bytelane: DATA_WIDTH must be 32");
  end
  if (READ_LATENCY < 1 || READ_LATENCY > 4) begin : g_bad_rl
    $error("data_memory_bytelane: READ_LATENCY must be 1..4");
  end

  dmem_state_e     state_q, state_n;
  logic [IW-1:0]   cnt_q, cnt_n;
  logic            ready_q, done_q;
  logic            clr_we;

  access_size_e    size;
  logic [1:0]      lo;
  logic [IW-1:0]   idx;
  logic            acc, fault, wr_st;
  logic [3:0]      be;
  logic [31:0]     wrep, ld, pipe_d;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  assign size  = access_size_e'(req_size);
  assign lo    = Address[1:0];
  assign idx   = Address[ADDR_WIDTH-1:2];
  assign acc   = req_valid & ready_q;
  assign fault = is_misaligned(size, lo);
  assign wr_st = acc & req_write & ~fault;
  assign be    = byte_enable(size, lo);

  always_comb begin
    state_n = state_q;
    cnt_n   = cnt_q;
    clr_we  = 1'b0;
    unique case (state_q)
      ST_INIT: begin
        clr_we = 1'b1;
        cnt_n  = cnt_q + 1'b1;
        if (cnt_q == IW'(DEPTH - 1)) state_n = ST_IDLE;
      end
      ST_IDLE: ;
      default: state_n = RST_ST;
    endcase
  end

  // Ready and init_done are registered so both read 0 while rst is high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RST_ST;
      cnt_q   <= '0;
      ready_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_n;
      cnt_q   <= cnt_n;
      ready_q <= (state_n == ST_IDLE);
      done_q  <= done_q | (state_n == ST_IDLE);
    end
  end

  always_comb begin
    wrep = Write_data;
    unique case (size)
      SZ_BYTE: wrep = {4{Write_data[7:0]}};
      SZ_HALF: wrep = {2{Write_data[15:0]}};
      default: wrep = Write_data;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem[cnt_q] <= '0;
    end else if (wr_st) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[idx][8*i +: 8] <= wrep[8*i +: 8];
      end
    end
  end

  assign ld     = extend_load(mem[idx], size, lo, req_unsigned);
  assign pipe_d = (req_write | fault) ? 32'd0 : ld;

  dmem_resp_pipe #(
    .LAT (READ_LATENCY),
    .W   (DATA_WIDTH)
  ) u_resp (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (acc),
    .in_fault  (fault),
    .in_data   (pipe_d),
    .out_valid (resp_valid),
    .out_fault (misaligned_fault),
    .out_data  (Read_data)
  );

  assign req_ready = ready_q;
  assign init_done = done_q;

endmodule

// File: tb/tb_data_memory_bytelane.sv
// Directed bench for data_memory_bytelane (DEPTH=16, READ_LATENCY=3).
// A monitor matches every response against an in-order expectation queue.
module tb_data_memory_bytelane;

  localparam int AW = 6;
  localparam int RL = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid, req_ready, req_write, req_unsigned;
  logic [1:0]    req_size;
  logic [AW-1:0] Address;
  logic [31:0]   Write_data, Read_data;
  logic          resp_valid, misaligned_fault, init_done;

  always #5 clk = ~clk;

  data_memory_bytelane #(
    .ADDR_WIDTH     (AW),
    .DATA_WIDTH     (32),
    .READ_LATENCY   (RL),
    .CLEAR_ON_RESET (1)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .req_valid        (req_valid),
    .req_ready        (req_ready),
    .req_write        (req_write),
    .req_size         (req_size),
    .req_unsigned     (req_unsigned),
    .Address          (Address),
    .Write_data       (Write_data),
    .resp_valid       (resp_valid),
    .Read_data        (Read_data),
    .misaligned_fault (misaligned_fault),
    .init_done        (init_done)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  typedef struct {
    string       tag;
    logic [31:0] d;
    logic        f;
    int          due;
  } exp_t;

  exp_t q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (resp_valid) begin
      if (q.size() == 0) begin
        chk("rsp_unexp", 32'(resp_valid), 32'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk({e.tag, "_data"}, Read_data, e.d);
        chk({e.tag, "_fault"}, 32'(misaligned_fault), 32'(e.f));
        chk({e.tag, "_lat"}, cyc, e.due);
      end
    end else begin
      chk("rsp_idle", Read_data | 32'(misaligned_fault), 32'd0);
    end
  end

  task automatic issue(input logic w, input logic [1:0] sz,
                       input logic u, input logic [AW-1:0] a,
                       input logic [31:0] wd, input logic [31:0] ed,
                       input logic ef, input string tag);
    exp_t e;
    req_valid    = 1'b1;
    req_write    = w;
    req_size     = sz;
    req_unsigned = u;
    Address      = a;
    Write_data   = wd;
    chk({tag, "_rdy"}, 32'(req_ready), 32'd1);
    @(posedge clk);
    #1;
    e.tag = tag;
    e.d   = ed;
    e.f   = ef;
    e.due = cyc + RL - 1;
    q.push_back(e);
  endtask

  task automatic idle(input int n);
    req_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    req_valid = 1'b0;
    while (q.size() != 0 && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain", q.size(), 32'd0);
  endtask

  task automatic wait_init(input string tag);
    int n;
    n = 0;
    chk({tag, "_done0"}, 32'(init_done), 32'd0);
    while (!req_ready && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk({tag, "_cycles"}, n, 32'd16);
    chk({tag, "_done1"}, 32'(init_done), 32'd1);
  endtask

  initial begin
    rst          = 1'b1;
    req_valid    = 1'b0;
    req_write    = 1'b0;
    req_size     = 2'b00;
    req_unsigned = 1'b0;
    Address      = '0;
    Write_data   = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_rvalid", 32'(resp_valid), 32'd0);
    chk("rst_rdata", Read_data, 32'd0);
    chk("rst_fault", 32'(misaligned_fault), 32'd0);
    chk("rst_done", 32'(init_done), 32'd0);
    rst = 1'b0;
    wait_init("init");

    issue(0, 2'b10, 0, 6'h08, 32'h0, 32'h0, 0, "lw08_clr");
    drain();

    issue(1, 2'b10, 0, 6'h10, 32'hDEADBEEF, 32'h0, 0, "sw10");
    issue(0, 2'b00, 0, 6'h13, 32'h0, 32'hFFFFFFDE, 0, "lb13");
    issue(0, 2'b00, 1, 6'h13, 32'h0, 32'h000000DE, 0, "lbu13");
    issue(0, 2'b01, 0, 6'h12, 32'h0, 32'hFFFFDEAD, 0, "lh12");
    issue(0, 2'b01, 1, 6'h10, 32'h0, 32'h0000BEEF, 0, "lhu10");
    drain();

    issue(1, 2'b10, 0, 6'h20, 32'h11223344, 32'h0, 0, "sw20");
    issue(1, 2'b00, 0, 6'h21, 32'hAAAAAA7F, 32'h0, 0, "sb21");
    issue(0, 2'b10, 0, 6'h20, 32'h0, 32'h11227F44, 0, "lw20");
    issue(0, 2'b00, 0, 6'h20, 32'h0, 32'h00000044, 0, "lb20");
    drain();

    issue(0, 2'b01, 0, 6'h11, 32'h0, 32'h0, 1, "lh11_mis");
    issue(1, 2'b10, 0, 6'h22, 32'hFFFFFFFF, 32'h0, 1, "sw22_mis");
    issue(1, 2'b11, 0, 6'h30, 32'hFFFFFFFF, 32'h0, 1, "rsvd30");
    issue(0, 2'b10, 0, 6'h10, 32'h0, 32'hDEADBEEF, 0, "rb10");
    issue(0, 2'b10, 0, 6'h20, 32'h0, 32'h11227F44, 0, "rb20");
    issue(0, 2'b10, 0, 6'h30, 32'h0, 32'h00000000, 0, "rb30");
    drain();

    issue(1, 2'b01, 0, 6'h32, 32'h1234A5B6, 32'h0, 0, "sh32");
    issue(0, 2'b10, 0, 6'h30, 32'h0, 32'hA5B60000, 0, "lw30");
    issue(0, 2'b01, 0, 6'h32, 32'h0, 32'hFFFFA5B6, 0, "lh32");
    drain();

    issue(1, 2'b10, 0, 6'h00, 32'hA0A0A0A0, 32'h0, 0, "sw00");
    issue(1, 2'b10, 0, 6'h04, 32'h0B0B0B0B, 32'h0, 0, "sw04");
    issue(1, 2'b10, 0, 6'h08, 32'hC0C0C0C0, 32'h0, 0, "sw08");
    idle(2);
    issue(0, 2'b10, 0, 6'h00, 32'h0, 32'hA0A0A0A0, 0, "b2b00");
    issue(0, 2'b10, 0, 6'h04, 32'h0, 32'h0B0B0B0B, 0, "b2b04");
    issue(0, 2'b10, 0, 6'h08, 32'h0, 32'hC0C0C0C0, 0, "b2b08");
    drain();

    issue(0, 2'b10, 0, 6'h10, 32'h0, 32'hDEADBEEF, 0, "fly10");
    issue(0, 2'b10, 0, 6'h20, 32'h0, 32'h11227F44, 0, "fly20");
    rst       = 1'b1;
    req_valid = 1'b0;
    q.delete();
    #1;
    chk("arst_done", 32'(init_done), 32'd0);
    chk("arst_ready", 32'(req_ready), 32'd0);
    chk("arst_rvalid", 32'(resp_valid), 32'd0);
    idle(2);
    rst = 1'b0;
    wait_init("reinit");
    issue(0, 2'b10, 0, 6'h10, 32'h0, 32'h0, 0, "lw10_clr");
    drain();
    idle(5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
